jk_stim_seq: RTL and testbench

//   Command-driven stimulus sequencer and checker sitting directly upstream of jk_ff.
//   - Accepts {op, len} commands over a valid/ready handshake.
//   - Drives jk_ff's j/k inputs for len+1 cycles per command.
//   - Tracks the expected Q with an internal JK model and compares it against jk_ff's Q every cycle.
//   - Turns the flop bench into a self-checking, command-scripted stage.

---
 rtl/jk_stim_seq_pkg.sv | 32 +++
 rtl/jk_ref_model.sv | 47 ++++
 rtl/jk_stim_seq.sv | 109 ++++++++++
 tb/tb_jk_stim_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_stim_seq_pkg.sv
// Shared definitions for the JK stimulus sequencer: op codes, FSM states
// and the JK next-state rule used by the expected-Q model.
package jk_stim_seq_pkg;

    // Command op codes; bit 1 drives j, bit 0 drives k.
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Next value of a JK flop given its current inputs and state.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic q_new;
        case ({j, k})
            2'b01:   q_new = 1'b0;
            2'b10:   q_new = 1'b1;
            2'b11:   q_new = ~q;
            default: q_new = q;
        endcase
        return q_new;
    endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Expected-Q model of the downstream JK flop plus the mismatch checker:
// a sticky error flag and a saturating mismatch counter.
module jk_ref_model
    import jk_stim_seq_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j,
    input  logic             k,
    input  logic             q_in,
    output logic             exp_q,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    logic             exp_q_reg;
    logic             chk_arm_reg;
    logic             err_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    // Model update and registered compare; the compare is held off for the
    // first edge after reset so the flop and model have settled together.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q_reg   <= 1'b0;
            chk_arm_reg <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            exp_q_reg   <= jk_next(j, k, exp_q_reg);
            chk_arm_reg <= 1'b1;
            if (chk_arm_reg && (q_in != exp_q_reg)) begin
                err_reg <= 1'b1;
                if (err_cnt_reg != {ERR_W{1'b1}}) begin
                    err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                end
            end
        end
    end

    assign exp_q   = exp_q_reg;
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: rtl/jk_stim_seq.sv
// Command-driven stimulus sequencer for a JK flop: accepts {op, len}
// commands, drives j/k for len+1 cycles, then drains one cycle and pulses
// done. The expected-Q checker lives in jk_ref_model.
module jk_stim_seq
    import jk_stim_seq_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             exp_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    state_e           state_reg, state_next;
    op_e              op_reg, op_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             j_reg, j_next;
    logic             k_reg, k_next;
    logic             done_reg, done_next;

    // State, counter and registered j/k/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_HOLD;
            cnt_reg   <= '0;
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in DRIVE, one DRAIN cycle.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        j_next     = 1'b0;
        k_next     = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next    = op_e'(cmd_op);
                    cnt_next   = cmd_len;
                    j_next     = cmd_op[1];
                    k_next     = cmd_op[0];
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - LEN_W'(1);
                    j_next   = op_reg[1];
                    k_next   = op_reg[0];
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Ready depends on state only, so there is no path from cmd_valid.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_DRIVE) || (state_reg == ST_DRAIN);
    assign j         = j_reg;
    assign k         = k_reg;
    assign done      = done_reg;

    jk_ref_model #(
        .ERR_W (ERR_W)
    ) u_ref_model (
        .clk     (clk),
        .rst     (rst),
        .j       (j_reg),
        .k       (k_reg),
        .q_in    (q_in),
        .exp_q   (exp_q),
        .err     (err),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_jk_stim_seq.sv
// Bench: jk_stim_seq driving a behavioural JK flop, with a q_in override
// to inject mismatches. Expected values come from command-level arithmetic.
module tb_jk_stim_seq;

    localparam int LEN_W = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             j;
    logic             k;
    logic             q_in;
    logic             exp_q;
    logic             busy;
    logic             done;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    logic ff_q;
    logic force_en;
    logic force_val;
    logic model_q;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] op;
        int         len;
        logic       fin_q;
        int         busy_cycles;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    // Downstream JK flop, reset by the same event as the sequencer.
    always @(posedge clk) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_in = force_en ? force_val : ff_q;

    jk_stim_seq #(
        .LEN_W (LEN_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .exp_q     (exp_q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Flop value after n edges of a given op starting from q0.
    function automatic logic q_after(input logic [1:0] op, input logic q0, input int n);
        if (n == 0) return q0;
        case (op)
            2'b00:   return q0;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return q0 ^ n[0];
        endcase
    endfunction

    // Issue one command from IDLE (called at a negedge) and check every cycle
    // through the done pulse; returns the number of busy cycles seen.
    task automatic run_cmd(input logic [1:0] op, input int len, input bit hold_valid,
                           output int busy_cycles);
        int   n;
        logic eq;
        busy_cycles = 0;
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        @(posedge clk);
        for (int i = 1; i <= len + 3; i++) begin
            @(negedge clk);
            if (i == 1 && !hold_valid) cmd_valid = 1'b0;
            if (i == len + 2) cmd_valid = 1'b0;
            n  = (i - 1 > len + 1) ? len + 1 : i - 1;
            eq = q_after(op, model_q, n);
            if (busy) busy_cycles++;
            chk("jk", {j, k}, (i <= len + 1) ? op : 2'b00);
            chk("busy", busy, (i <= len + 2) ? 1 : 0);
            chk("ready", cmd_ready, (i == len + 3) ? 1 : 0);
            chk("done", done, (i == len + 3) ? 1 : 0);
            chk("exp_q", exp_q, eq);
            chk("q_in", q_in, eq);
            chk("err", err, 0);
        end
        model_q = q_after(op, model_q, len + 1);
        $display("cmd op=%0d len=%0d busy=%0d q=%0b", op, len, busy_cycles, q_in);
    endtask

    initial begin
        int bc;
        int gap;
        logic [1:0] rop;
        int rlen;

        tbl[0] = '{op: 2'b10, len: 2,  fin_q: 1'b1, busy_cycles: 4};
        tbl[1] = '{op: 2'b11, len: 3,  fin_q: 1'b1, busy_cycles: 5};
        tbl[2] = '{op: 2'b01, len: 0,  fin_q: 1'b0, busy_cycles: 2};
        tbl[3] = '{op: 2'b00, len: 15, fin_q: 1'b0, busy_cycles: 17};
        tbl[4] = '{op: 2'b11, len: 0,  fin_q: 1'b1, busy_cycles: 2};
        tbl[5] = '{op: 2'b11, len: 15, fin_q: 1'b1, busy_cycles: 17};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        force_en  = 1'b0;
        force_val = 1'b0;
        model_q   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_jk", {j, k}, 2'b00);
        chk("rst_exp_q", exp_q, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        $display("reset: jk=%0b%0b exp_q=%0b ready=%0b", j, k, exp_q, cmd_ready);

        // Directed command table
        foreach (tbl[t]) begin
            run_cmd(tbl[t].op, tbl[t].len, 1'b0, bc);
            chk("tbl_final_q", q_in, tbl[t].fin_q);
            chk("tbl_busy_cycles", bc, tbl[t].busy_cycles);
        end

        // Mismatch injection: bring Q to 0, then force q_in high
        run_cmd(2'b01, 0, 1'b0, bc);
        force_en  = 1'b1;
        force_val = 1'b1;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        chk("inj_err", err, 1);
        chk("inj_err_cnt3", err_cnt, 3);
        $display("inject3: err=%0b err_cnt=%0d", err, err_cnt);
        repeat (2) @(negedge clk);
        chk("inj_err_cnt_hold", err_cnt, 3);
        force_en = 1'b1;
        repeat (260) @(negedge clk);
        force_en = 1'b0;
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_err", err, 1);
        @(negedge clk);
        chk("sat_err_cnt_hold", err_cnt, 255);
        $display("saturate: err=%0b err_cnt=%0d", err, err_cnt);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_err_cnt", err_cnt, 0);
        @(negedge clk);

        // Reset mid-DRIVE, with a pending command held through the busy period
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = LEN_W'(10);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = LEN_W'(1);
        @(negedge clk);
        chk("abort_drive_jk", {j, k}, 2'b11);
        chk("abort_drive_busy", busy, 1);
        @(negedge clk);
        chk("abort_drive_jk2", {j, k}, 2'b11);
        chk("abort_ready", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_jk", {j, k}, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_exp_q", exp_q, 0);
        chk("abort_err", err, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_ready_idle", cmd_ready, 1);
        $display("abort: jk=%0b%0b busy=%0b done=%0b", j, k, busy, done);
        model_q = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pend_jk", {j, k}, 2'b10);
        chk("pend_busy", busy, 1);
        chk("pend_done", done, 0);
        @(negedge clk);
        chk("pend_jk2", {j, k}, 2'b10);
        @(negedge clk);
        chk("pend_drain_jk", {j, k}, 2'b00);
        chk("pend_drain_busy", busy, 1);
        @(negedge clk);
        chk("pend_done_pulse", done, 1);
        chk("pend_q", q_in, 1);
        chk("pend_exp_q", exp_q, 1);
        model_q = 1'b1;
        $display("pending: done=%0b q=%0b", done, q_in);

        // Randomized commands against the command-level model
        for (int r = 0; r < 30; r++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_exp_q", exp_q, model_q);
                chk("gap_q_in", q_in, model_q);
            end
            rop  = 2'($urandom_range(0, 3));
            rlen = $urandom_range(0, 15);
            run_cmd(rop, rlen, 1'($urandom_range(0, 1)), bc);
            chk("rnd_busy_cycles", bc, rlen + 2);
        end
        chk("rnd_err_cnt", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
